mdu_div: RTL

- Iterative multi-cycle divider for the pipelined MIPS core; implements DIV and DIVU.
- Quotient goes to LO and remainder to HI.
- The execute stage launches it with a start pulse and stalls on busy.
- Restoring, radix-2, one quotient bit per clock; sign handled by absolute-value pre-step and conditional-negate post-step.

---
 rtl/mdu_div_pkg.sv | 14 +
 rtl/mdu_div_if.sv | 25 ++
 rtl/mdu_div_negate_cond.sv | 16 +
 rtl/mdu_div.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mdu_div_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: FSM state
// encodings and the divide-by-zero quotient fill value.
package mdu_div_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Every quotient bit is set on a divide by zero; the multiplier block
    // reuses this so both halves of the unit agree on the pattern.
    localparam logic DIVZERO_QBIT = 1'b1;

endpackage

// File: rtl/mdu_div_if.sv
// Handshake and data bundle between the execute stage and the divider.
interface mdu_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sgn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             divzero;

    modport master (
        output start, sgn, a, b, flush,
        input  busy, done, q, r, divzero
    );

    modport slave (
        input  start, sgn, a, b, flush,
        output busy, done, q, r, divzero
    );
endinterface

// File: rtl/mdu_div_negate_cond.sv
// Conditional two's-complement negate: y = en ? -a : a, built as an
// invert followed by an increment of the enable bit.
module negate_cond #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] y_o
);

    // Invert every bit when enabled, then add one to finish the negate.
    always_comb begin
        y_o = (a_i ^ {WIDTH{en_i}}) + {{(WIDTH-1){1'b0}}, en_i};
    end

endmodule

// File: rtl/mdu_div.sv
// Iterative restoring radix-2 divider for DIV/DIVU. Quotient goes to LO,
// remainder to HI. Operands are made non-negative before iterating and the
// results are sign-corrected in a single fix-up cycle afterwards.
module mdu_div
    import mdu_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    mdu_div_if.slave   bus
);

    localparam int CNTW = $clog2(WIDTH) + 1;

    logic [1:0]       state_q,   state_d;
    logic [CNTW-1:0]  cnt_q,     cnt_d;
    logic             negQ_q,    negQ_d;
    logic             negR_q,    negR_d;
    logic             zeroPend_q, zeroPend_d;
    logic [WIDTH-1:0] absB_q,    absB_d;
    logic [WIDTH-1:0] rem_q,     rem_d;
    logic [WIDTH-1:0] dvd_q,     dvd_d;
    logic [WIDTH-1:0] q_q,       q_d;
    logic [WIDTH-1:0] r_q,       r_d;
    logic             divzero_q, divzero_d;

    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH-1:0] fixQ;
    logic [WIDTH-1:0] fixR;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             trialOk;

    negate_cond #(.WIDTH(WIDTH)) uAbsA (
        .a_i  (bus.a),
        .en_i (bus.sgn & bus.a[WIDTH-1]),
        .y_o  (absA)
    );

    negate_cond #(.WIDTH(WIDTH)) uAbsB (
        .a_i  (bus.b),
        .en_i (bus.sgn & bus.b[WIDTH-1]),
        .y_o  (absB)
    );

    negate_cond #(.WIDTH(WIDTH)) uFixQ (
        .a_i  (dvd_q),
        .en_i (negQ_q),
        .y_o  (fixQ)
    );

    negate_cond #(.WIDTH(WIDTH)) uFixR (
        .a_i  (rem_q),
        .en_i (negR_q),
        .y_o  (fixR)
    );

    // Trial subtract of the shifted partial remainder against |b|. Because the
    // remainder always stays below |b|, a WIDTH+1-bit difference is enough and
    // its top bit is a reliable borrow indicator.
    always_comb begin
        shifted = {rem_q, dvd_q[WIDTH-1]};
        diff    = shifted + {1'b1, ~absB_q} + {{WIDTH{1'b0}}, 1'b1};
        trialOk = ~diff[WIDTH];
    end

    // Next-state logic. Flush wins over everything and leaves the presented
    // results alone. A zero divisor skips the iteration and uses the fix-up
    // cycle to publish the all-ones quotient and the raw dividend.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        negQ_d     = negQ_q;
        negR_d     = negR_q;
        zeroPend_d = zeroPend_q;
        absB_d     = absB_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        q_d        = q_q;
        r_d        = r_q;
        divzero_d  = divzero_q;

        if (bus.flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        negQ_d     = bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        negR_d     = bus.sgn & bus.a[WIDTH-1];
                        zeroPend_d = (bus.b == '0);
                        absB_d     = absB;
                        rem_d      = '0;
                        cnt_d      = '0;
                        dvd_d      = zeroPend_d ? bus.a : absA;
                        state_d    = zeroPend_d ? ST_FIX : ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    rem_d = trialOk ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], trialOk};
                    cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
                    if (cnt_q == CNTW'(WIDTH - 1)) begin
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (zeroPend_q) begin
                        q_d       = {WIDTH{DIVZERO_QBIT}};
                        r_d       = dvd_q;
                        divzero_d = 1'b1;
                    end else begin
                        q_d       = fixQ;
                        r_d       = fixR;
                        divzero_d = 1'b0;
                    end
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            negQ_q     <= 1'b0;
            negR_q     <= 1'b0;
            zeroPend_q <= 1'b0;
            absB_q     <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            q_q        <= '0;
            r_q        <= '0;
            divzero_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            negQ_q     <= negQ_d;
            negR_q     <= negR_d;
            zeroPend_q <= zeroPend_d;
            absB_q     <= absB_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            q_q        <= q_d;
            r_q        <= r_d;
            divzero_q  <= divzero_d;
        end
    end

    // Status flags decode straight from the state so reset clears them
    // without waiting for a clock edge.
    always_comb begin
        bus.busy    = (state_q == ST_RUN) || (state_q == ST_FIX);
        bus.done    = (state_q == ST_DONE);
        bus.q       = q_q;
        bus.r       = r_q;
        bus.divzero = divzero_q;
    end

endmodule
